// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: four BCD digits advanced by a 1 Hz tick while running,
// or stepped one field at a time by a 2 Hz tick in adjust mode.
module stopwatch_counter #(
   parameter int unsigned MIN_MAX = 59,
   parameter int unsigned SEC_MAX = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       tick_adj,
   input  logic       adj,
   input  logic       sel,
   input  logic       pause_pulse,
   input  logic       clear_pulse,
   output logic [3:0] minutes_tens,
   output logic [3:0] minutes_ones,
   output logic [3:0] seconds_tens,
   output logic [3:0] seconds_ones,
   output logic       running,
   output logic       adjusting,
   output logic       rollover
);

   localparam logic [3:0] MinTens = 4'(MIN_MAX / 10);
   localparam logic [3:0] MinOnes = 4'(MIN_MAX % 10);
   localparam logic [3:0] SecTens = 4'(SEC_MAX / 10);
   localparam logic [3:0] SecOnes = 4'(SEC_MAX % 10);

   typedef enum logic [1:0] {StStopped, StRunning, StAdjust} state_e;

   state_e     state_q, state_d;
   logic       run_saved_q, run_saved_d;
   logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
   logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
   logic       running_q, running_d, adjusting_q, adjusting_d;
   logic       rollover_q, rollover_d;
   logic       tick_1hz_prev_q, tick_adj_prev_q;
   logic       cnt_en, adj_en;
   logic [8:0] sec_inc, min_inc;

   // Returns {wrap, tens, ones} for a two-digit BCD field incremented by one.
   function automatic logic [8:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                          input logic [3:0] max_tens,
                                          input logic [3:0] max_ones);
      if (tens == max_tens && ones == max_ones) begin
         return 9'h100;
      end else if (ones >= 4'd9) begin
         return {1'b0, tens + 4'd1, 4'd0};
      end else begin
         return {1'b0, tens, ones + 4'd1};
      end
   endfunction

   // Rising-edge qualify so a stretched pulse still counts only once.
   assign cnt_en  = tick_1hz & ~tick_1hz_prev_q;
   assign adj_en  = tick_adj & ~tick_adj_prev_q;
   assign sec_inc = bcd_inc(sec_tens_q, sec_ones_q, SecTens, SecOnes);
   assign min_inc = bcd_inc(min_tens_q, min_ones_q, MinTens, MinOnes);

   always_comb begin
      state_d     = state_q;
      run_saved_d = run_saved_q;
      min_tens_d  = min_tens_q;
      min_ones_d  = min_ones_q;
      sec_tens_d  = sec_tens_q;
      sec_ones_d  = sec_ones_q;
      rollover_d  = 1'b0;

      if (clear_pulse) begin
         min_tens_d = 4'd0;
         min_ones_d = 4'd0;
         sec_tens_d = 4'd0;
         sec_ones_d = 4'd0;
      end else if (state_q == StRunning && cnt_en) begin
         {sec_tens_d, sec_ones_d} = sec_inc[7:0];
         if (sec_inc[8]) begin
            {min_tens_d, min_ones_d} = min_inc[7:0];
            rollover_d = min_inc[8];
         end
      end else if (state_q == StAdjust && adj_en) begin
         if (sel) begin
            {sec_tens_d, sec_ones_d} = sec_inc[7:0];
         end else begin
            {min_tens_d, min_ones_d} = min_inc[7:0];
         end
      end

      unique case (state_q)
         StStopped: begin
            if (adj) begin
               state_d     = StAdjust;
               run_saved_d = 1'b0;
            end else if (pause_pulse) begin
               state_d = StRunning;
            end
         end
         StRunning: begin
            if (adj) begin
               state_d     = StAdjust;
               run_saved_d = 1'b1;
            end else if (pause_pulse) begin
               state_d = StStopped;
            end
         end
         StAdjust: begin
            if (!adj) state_d = run_saved_q ? StRunning : StStopped;
         end
         default: state_d = StStopped;
      endcase

      running_d   = (state_d == StRunning);
      adjusting_d = (state_d == StAdjust);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StStopped;
         run_saved_q     <= 1'b0;
         min_tens_q      <= 4'd0;
         min_ones_q      <= 4'd0;
         sec_tens_q      <= 4'd0;
         sec_ones_q      <= 4'd0;
         running_q       <= 1'b0;
         adjusting_q     <= 1'b0;
         rollover_q      <= 1'b0;
         tick_1hz_prev_q <= 1'b0;
         tick_adj_prev_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         run_saved_q     <= run_saved_d;
         min_tens_q      <= min_tens_d;
         min_ones_q      <= min_ones_d;
         sec_tens_q      <= sec_tens_d;
         sec_ones_q      <= sec_ones_d;
         running_q       <= running_d;
         adjusting_q     <= adjusting_d;
         rollover_q      <= rollover_d;
         tick_1hz_prev_q <= tick_1hz;
         tick_adj_prev_q <= tick_adj;
      end
   end

   assign minutes_tens = min_tens_q;
   assign minutes_ones = min_ones_q;
   assign seconds_tens = sec_tens_q;
   assign seconds_ones = sec_ones_q;
   assign running      = running_q;
   assign adjusting    = adjusting_q;
   assign rollover     = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; digits are compared as a 16-bit BCD
// MMSS word against hand-computed values.
module tb_stopwatch_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1hz, tick_adj, adj, sel, pause_pulse, clear_pulse;
   logic [3:0] minutes_tens, minutes_ones, seconds_tens, seconds_ones;
   logic       running, adjusting, rollover;

   int checks = 0;
   int errors = 0;

   stopwatch_counter #(
      .MIN_MAX(59),
      .SEC_MAX(59)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_1hz    (tick_1hz),
      .tick_adj    (tick_adj),
      .adj         (adj),
      .sel         (sel),
      .pause_pulse (pause_pulse),
      .clear_pulse (clear_pulse),
      .minutes_tens(minutes_tens),
      .minutes_ones(minutes_ones),
      .seconds_tens(seconds_tens),
      .seconds_ones(seconds_ones),
      .running     (running),
      .adjusting   (adjusting),
      .rollover    (rollover)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mmss();
      return {minutes_tens, minutes_ones, seconds_tens, seconds_ones};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive pulses for one clock edge; outputs are sampled 1 ns after that edge.
   task automatic step(input logic t1, input logic ta, input logic p, input logic c);
      tick_1hz    = t1;
      tick_adj    = ta;
      pause_pulse = p;
      clear_pulse = c;
      @(posedge clk);
      #1;
      tick_1hz    = 1'b0;
      tick_adj    = 1'b0;
      pause_pulse = 1'b0;
      clear_pulse = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         idle();
      end
   endtask

   task automatic adj_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         idle();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {tick_1hz, tick_adj, adj, sel, pause_pulse, clear_pulse} = '0;
      #12;
      check_eq("reset_digits", 32'(mmss()), 32'h0000);
      check_eq("reset_flags", {29'd0, running, adjusting, rollover}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: start and count five seconds
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("t1_running", 32'(running), 32'd1);
      ticks(5);
      check_eq("t1_digits", 32'(mmss()), 32'h0005);
      check_eq("t1_rollover", 32'(rollover), 32'd0);

      // 2: set 00:59 via adjust, return to running, tick over the minute
      adj = 1'b1; sel = 1'b1;
      idle();
      check_eq("t2_adjusting", 32'(adjusting), 32'd1);
      adj_ticks(54);
      check_eq("t2_preload_0059", 32'(mmss()), 32'h0059);
      adj = 1'b0;
      idle();
      check_eq("t2_resume_running", 32'(running), 32'd1);
      ticks(1);
      check_eq("t2_min_carry", 32'(mmss()), 32'h0100);
      adj = 1'b1; sel = 1'b0;
      idle();
      adj_ticks(58);
      sel = 1'b1;
      adj_ticks(59);
      check_eq("t2_preload_5959", 32'(mmss()), 32'h5959);
      adj = 1'b0;
      idle();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("t2_wrap_digits", 32'(mmss()), 32'h0000);
      check_eq("t2_rollover_hi", 32'(rollover), 32'd1);
      idle();
      check_eq("t2_rollover_lo", 32'(rollover), 32'd0);

      // 3: adjust from 12:34 while running; 1 Hz ticks ignored in adjust
      adj = 1'b1; sel = 1'b0;
      idle();
      adj_ticks(12);
      sel = 1'b1;
      adj_ticks(34);
      adj = 1'b0;
      idle();
      check_eq("t3_preload_1234", 32'(mmss()), 32'h1234);
      adj = 1'b1; sel = 1'b0;
      idle();
      adj_ticks(1);
      ticks(1);
      adj_ticks(1);
      ticks(1);
      adj_ticks(1);
      check_eq("t3_min_adjust", 32'(mmss()), 32'h1534);
      sel = 1'b1;
      adj_ticks(24);
      check_eq("t3_at_1558", 32'(mmss()), 32'h1558);
      adj_ticks(3);
      check_eq("t3_sec_wrap_no_carry", 32'(mmss()), 32'h1501);
      adj = 1'b0;
      idle();
      check_eq("t3_back_running", {30'd0, running, adjusting}, 32'b10);

      // 4: pause with coincident tick, from STOPPED then from RUNNING
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("t4_stopped", 32'(running), 32'd0);
      adj = 1'b1; sel = 1'b1;
      idle();
      adj_ticks(10);
      adj = 1'b0;
      idle();
      check_eq("t4_stopped_0010", {15'd0, running, mmss()}, 32'h0010);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("t4_start_no_count", {15'd0, running, mmss()}, 32'h1_0010);
      idle();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("t4_stop_counted", {15'd0, running, mmss()}, 32'h0011);

      // 5: clear beats tick in RUNNING; clear in ADJUST keeps state
      adj = 1'b1; sel = 1'b0;
      idle();
      adj_ticks(3);
      sel = 1'b1;
      adj_ticks(56);
      adj = 1'b0;
      idle();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("t5_running_0307", {15'd0, running, mmss()}, 32'h1_0307);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("t5_clear_running", {15'd0, running, mmss()}, 32'h1_0000);
      idle();
      check_eq("t5_tick_dropped", 32'(mmss()), 32'h0000);
      adj = 1'b1; sel = 1'b0;
      idle();
      adj_ticks(2);
      check_eq("t5_adj_0200", 32'(mmss()), 32'h0200);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("t5_clear_adjust", {15'd0, adjusting, mmss()}, 32'h1_0000);

      // 6: asynchronous reset in the middle of adjust
      adj_ticks(45);
      sel = 1'b1;
      adj_ticks(30);
      check_eq("t6_at_4530", 32'(mmss()), 32'h4530);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_digits", 32'(mmss()), 32'h0000);
      check_eq("t6_async_flags", {29'd0, running, adjusting, rollover}, 32'd0);
      adj = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      check_eq("t6_after_release", {13'd0, running, adjusting, rollover, mmss()}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
